// File: rtl/mulu_iter.sv
// Iterative unsigned fixed-point multiplier: val = (a*b) >> FBITS, truncated.
// One shift-add step per cycle, constant WIDTH-cycle latency, start/busy/done/valid/ovf handshake.
module mulu_iter #(
  parameter int WIDTH = 8,
  parameter int FBITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             valid,
  output logic             ovf,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] val
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PW = 2 * WIDTH;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [CW-1:0]    i_q, i_d;

  logic [PW-1:0]    a1_wide;
  logic [PW-1:0]    addend;
  logic [PW-1:0]    prod_next;

  // Partial product for the current step, kept at full product width so nothing is lost.
  assign a1_wide   = {{WIDTH{1'b0}}, a1_q};
  assign addend    = b1_q[i_q] ? (a1_wide << i_q) : '0;
  assign prod_next = prod_q + addend;

  always_comb begin
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    val_d   = val_q;
    a1_d    = a1_q;
    b1_d    = b1_q;
    prod_d  = prod_q;
    i_d     = i_q;

    if (busy_q) begin
      prod_d = prod_next;
      i_d    = i_q + 1'b1;
      if (i_q == LAST_STEP) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        // Any set bit above the result window means the integer part does not fit.
        if (|prod_next[PW-1:WIDTH+FBITS]) begin
          ovf_d   = 1'b1;
          valid_d = 1'b0;
          val_d   = '0;
        end else begin
          valid_d = 1'b1;
          val_d   = prod_next[WIDTH+FBITS-1:FBITS];
        end
      end
    end else if (start) begin
      a1_d    = a;
      b1_d    = b;
      prod_d  = '0;
      i_d     = '0;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      val_q   <= '0;
      a1_q    <= '0;
      b1_q    <= '0;
      prod_q  <= '0;
      i_q     <= '0;
    end else begin
      busy_q  <= busy_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      val_q   <= val_d;
      a1_q    <= a1_d;
      b1_q    <= b1_d;
      prod_q  <= prod_d;
      i_q     <= i_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign valid = valid_q;
  assign ovf   = ovf_q;
  assign val   = val_q;

endmodule
